// File: rtl/rx_bit_unstuff_ctrl.sv
// rx_bit_unstuff_ctrl: USB RX bit unstuffer with run counter and stuff-bit stats.
// Optional STUFF_ERR_EN: a stuffed 1 sets stuff_err and locks ERROR until enable drops.
module rx_bit_unstuff_ctrl #(
  parameter int RUN_LEN = 6,
  parameter int STAT_W  = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              enable,
  input  logic              bit_valid,
  input  logic              decoded_bit,
  output logic              out_valid,
  output logic              out_bit,
  output logic              ignore_bit,
  output logic              stuff_err,
  output logic [STAT_W-1:0] stuff_cnt
);
  localparam int CNT_W = $clog2(RUN_LEN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);

`ifdef STUFF_ERR_EN
  typedef enum logic [1:0] {IDLE, RUN, ERROR} state_t;
`else
  typedef enum logic [0:0] {IDLE, RUN} state_t;
`endif

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  ones_q;
  logic [CNT_W-1:0]  ones_d;
  logic [CNT_W-1:0]  ones_cur;
  logic              out_valid_d;
  logic              out_bit_d;
  logic              ignore_d;
  logic [STAT_W-1:0] cnt_d;
  logic              accept;
  logic              is_stuff;
`ifdef STUFF_ERR_EN
  logic              err_q;
  logic              err_d;
`endif

  always_comb begin
    state_d     = state_q;
    ones_d      = ones_q;
    ones_cur    = ones_q;
    out_valid_d = 1'b0;
    out_bit_d   = out_bit;
    ignore_d    = 1'b0;
    cnt_d       = stuff_cnt;
    accept      = 1'b0;
    is_stuff    = 1'b0;
`ifdef STUFF_ERR_EN
    err_d       = err_q;
`endif
    if (!enable) begin
      state_d = IDLE;
      ones_d  = '0;
      cnt_d   = '0;
`ifdef STUFF_ERR_EN
      err_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d  = RUN;
          ones_cur = '0;
          accept   = bit_valid;
        end
        RUN:   accept = bit_valid;
`ifdef STUFF_ERR_EN
        ERROR: accept = 1'b0;
`endif
      endcase
      is_stuff = (ones_cur == RUN_MAX);
      if (accept) begin
        unique case (1'b1)
          is_stuff: begin
            ignore_d = 1'b1;
            ones_d   = '0;
            if (stuff_cnt != '1)
              cnt_d = stuff_cnt + STAT_W'(1);
`ifdef STUFF_ERR_EN
            if (decoded_bit) begin
              err_d   = 1'b1;
              state_d = ERROR;
            end
`endif
          end
          (!is_stuff && decoded_bit): begin
            out_valid_d = 1'b1;
            out_bit_d   = 1'b1;
            ones_d      = ones_cur + CNT_W'(1);
          end
          (!is_stuff && !decoded_bit): begin
            out_valid_d = 1'b1;
            out_bit_d   = 1'b0;
            ones_d      = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      ones_q     <= '0;
      out_valid  <= 1'b0;
      out_bit    <= 1'b0;
      ignore_bit <= 1'b0;
      stuff_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      ones_q     <= ones_d;
      out_valid  <= out_valid_d;
      out_bit    <= out_bit_d;
      ignore_bit <= ignore_d;
      stuff_cnt  <= cnt_d;
    end
  end

`ifdef STUFF_ERR_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign stuff_err = err_q;
`else
  assign stuff_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_bit_unstuff_ctrl.sv
// Bench for rx_bit_unstuff_ctrl: RUN_LEN=6/STAT_W=8 and RUN_LEN=3/STAT_W=2 instances
// share inputs; a behavioural model queues expected outputs per cycle.
module tb_rx_bit_unstuff_ctrl;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic enable = 1'b0;
  logic bit_valid = 1'b0;
  logic decoded_bit = 1'b0;

  logic       a_ov, a_ob, a_ig, a_err;
  logic [7:0] a_cnt;
  logic       b_ov, b_ob, b_ig, b_err;
  logic [1:0] b_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit ov;
    bit ob;
    bit ig;
    bit err;
    int cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int m_ones[2];
  int m_cnt[2];
  bit m_err[2];
  bit m_ob[2];
  int run_len[2] = '{6, 3};
  int cnt_max[2] = '{255, 3};
`ifdef STUFF_ERR_EN
  bit err_en = 1'b1;
`else
  bit err_en = 1'b0;
`endif

  always #5 clk = ~clk;

  rx_bit_unstuff_ctrl #(.RUN_LEN(6), .STAT_W(8)) dut_a (
    .clk(clk), .n_rst(n_rst), .enable(enable),
    .bit_valid(bit_valid), .decoded_bit(decoded_bit),
    .out_valid(a_ov), .out_bit(a_ob), .ignore_bit(a_ig),
    .stuff_err(a_err), .stuff_cnt(a_cnt)
  );

  rx_bit_unstuff_ctrl #(.RUN_LEN(3), .STAT_W(2)) dut_b (
    .clk(clk), .n_rst(n_rst), .enable(enable),
    .bit_valid(bit_valid), .decoded_bit(decoded_bit),
    .out_valid(b_ov), .out_bit(b_ob), .ignore_bit(b_ig),
    .stuff_err(b_err), .stuff_cnt(b_cnt)
  );

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(int i, bit en, bit v, bit b);
    exp_t e;
    e.ov = 1'b0;
    e.ig = 1'b0;
    if (!en) begin
      m_ones[i] = 0;
      m_cnt[i]  = 0;
      m_err[i]  = 1'b0;
    end else if (!m_err[i] && v) begin
      if (m_ones[i] == run_len[i]) begin
        e.ig = 1'b1;
        m_ones[i] = 0;
        if (m_cnt[i] < cnt_max[i]) m_cnt[i]++;
        if (b && err_en) m_err[i] = 1'b1;
      end else begin
        e.ov = 1'b1;
        m_ob[i] = b;
        m_ones[i] = b ? m_ones[i] + 1 : 0;
      end
    end
    e.ob  = m_ob[i];
    e.err = m_err[i];
    e.cnt = m_cnt[i];
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic compare(string n, int i, bit ov, bit ob, bit ig, bit err, int cnt);
    exp_t e;
    if (i == 0 && q0.size() == 0 || i == 1 && q1.size() == 0) begin
      chk({n, "_queue_empty"}, 1, 0);
      return;
    end
    e = (i == 0) ? q0.pop_front() : q1.pop_front();
    chk({n, "_out_valid"}, int'(ov), int'(e.ov));
    chk({n, "_out_bit"}, int'(ob), int'(e.ob));
    chk({n, "_ignore_bit"}, int'(ig), int'(e.ig));
    chk({n, "_stuff_err"}, int'(err), int'(e.err));
    chk({n, "_stuff_cnt"}, cnt, e.cnt);
  endtask

  task automatic cyc(bit en, bit v, bit b);
    enable = en;
    bit_valid = v;
    decoded_bit = b;
    model(0, en, v, b);
    model(1, en, v, b);
    @(posedge clk);
    #1;
    compare("a", 0, a_ov, a_ob, a_ig, a_err, int'(a_cnt));
    compare("b", 1, b_ov, b_ob, b_ig, b_err, int'(b_cnt));
  endtask

  task automatic send(bit b);
    cyc(1'b1, 1'b1, b);
  endtask

  task automatic reset_chk(string n);
    chk({n, "_a_ov"}, int'(a_ov), 0);
    chk({n, "_a_ob"}, int'(a_ob), 0);
    chk({n, "_a_ig"}, int'(a_ig), 0);
    chk({n, "_a_err"}, int'(a_err), 0);
    chk({n, "_a_cnt"}, int'(a_cnt), 0);
    chk({n, "_b_ov"}, int'(b_ov), 0);
    chk({n, "_b_cnt"}, int'(b_cnt), 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ones[i] = 0;
      m_cnt[i]  = 0;
      m_err[i]  = 1'b0;
      m_ob[i]   = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    #2;
    reset_chk("por");
    #6;
    n_rst = 1'b1;

    // 1,1,1,1,1,1,0,1 then idle
    cyc(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) send(1'b1);
    send(1'b0);
    send(1'b1);
    chk("seq1_cnt", int'(a_cnt), 1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // zero breaks the run; stuff on final 0
    for (int k = 0; k < 4; k++) send(1'b1);
    send(1'b0);
    for (int k = 0; k < 6; k++) send(1'b1);
    send(1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // enable drop mid-run restarts counter; bit during drop discarded
    for (int k = 0; k < 5; k++) send(1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) send(1'b1);
    cyc(1'b0, 1'b0, 1'b0);

    // saturation on the small instance
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 3; k++) send(1'b1);
      send(1'b0);
    end
    chk("sat_b_cnt", int'(b_cnt), 3);
    cyc(1'b0, 1'b0, 1'b0);

    // seven ones: stuffed 1 (violation when enabled), then more bits
    for (int k = 0; k < 7; k++) send(1'b1);
    for (int k = 0; k < 3; k++) send(1'b1);
    send(1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);

    // gapped bits, async reset mid-packet
    for (int k = 0; k < 4; k++) begin
      send(1'b1);
      cyc(1'b1, 1'b0, 1'b0);
    end
    n_rst = 1'b0;
    enable = 1'b0;
    bit_valid = 1'b0;
    #1;
    reset_chk("mid_rst");
    model_reset();
    #2;
    n_rst = 1'b1;
    for (int k = 0; k < 7; k++) begin
      send(1'b1);
      cyc(1'b1, 1'b0, 1'b0);
    end
    send(1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rx_bit_unstuff_ctrl.md
# rx_bit_unstuff_ctrl

Parametrised bit-unstuffing controller for the USB RX datapath, placed between the NRZI decoder and the shift register. It counts consecutive decoded ones across valid bit strobes, drops the stuffed bit after a run of RUN_LEN ones, and flags stuff violations. It also keeps a saturating count of removed stuff bits for status reporting. All outputs are registered.

## Interface
- RUN_LEN, 6: consecutive ones that force a stuffed bit; legal range 1..15.
- STAT_W, 8: width of the saturating stuff-bit counter.
- CNT_W (localparam) = $clog2(RUN_LEN+1): run counter width.

- clk  in  1  clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- enable  in  1  packet active (high from SYNC to EOP); low clears run state.
- bit_valid  in  1  one-cycle strobe; decoded_bit is meaningful this cycle.
- decoded_bit  in  1  NRZI-decoded bit.
- out_valid  out  1  registered strobe; out_bit is a data bit (not stuffed).
- out_bit  out  1  registered copy of the accepted decoded_bit.
- ignore_bit  out  1  registered strobe; the bit just received was a stuff bit.
- stuff_err  out  1  sticky stuff-violation flag.
- stuff_cnt  out  STAT_W  saturating count of removed stuff bits in the current packet.

## Operation
- Internal run counter `ones` (CNT_W bits) and FSM states IDLE, RUN, ERROR.
- IDLE: `ones`=0. If enable=1, go to RUN. A bit_valid in the same cycle is processed as in RUN with `ones`=0.
- RUN, when bit_valid=1 (bit is "accepted"):
  - `ones`<RUN_LEN, decoded_bit=1: `ones`+1; out_valid=1, out_bit=1.
  - `ones`<RUN_LEN, decoded_bit=0: `ones`=0; out_valid=1, out_bit=0.
  - `ones`==RUN_LEN: this is the stuff bit. ignore_bit=1, out_valid=0, `ones`=0, stuff_cnt+1 (saturating at all-ones).
  - If that stuff bit is also 1, a violation is raised (see Configuration).
- RUN with bit_valid=0: no state change; out_valid=0 and ignore_bit=0.
- ERROR: no bits are accepted. out_valid and ignore_bit stay 0. stuff_err holds 1.
- From any state, enable=0 forces IDLE on the next edge. This clears `ones`, stuff_err and stuff_cnt. A bit_valid in that cycle is discarded.
- out_valid and ignore_bit are never high together.

## Timing
- Latency: out_valid, out_bit, ignore_bit and stuff_err update one clk after the input cycle.
- stuff_cnt updates one clk after the stuff bit's input cycle.
- out_valid and ignore_bit are single-cycle pulses.
- out_bit holds its last value when out_valid=0.
- Reset values: state=IDLE, `ones`=0, out_valid=0, out_bit=0, ignore_bit=0, stuff_err=0, stuff_cnt=0.
- Reset asserted mid-packet takes effect immediately; the pending bit is lost.
- Back-to-back bit_valid on consecutive cycles is supported with no throughput loss.

## Configuration
- STUFF_ERR_EN defined:
  - A stuff bit of value 1 sets stuff_err on the next clock (same cycle as ignore_bit).
  - The FSM enters ERROR and stays there until enable=0.
- STUFF_ERR_EN undefined:
  - stuff_err is tied to 0 and the ERROR state is not built.
  - A stuff bit of value 1 is dropped like any stuff bit: ignore_bit=1, `ones`=0, stay in RUN.

## Test plan
- RUN_LEN=6, enable=1, bits 1,1,1,1,1,1,0,1: six out_valid pulses with out_bit=1; ignore_bit pulse on the 7th bit; 8th bit gives out_valid with out_bit=1; stuff_cnt=1.
- Bits 1,1,1,1,0,1,1,1,1,1,1,0: no ignore_bit on the 5th bit (the zero resets the run); ignore_bit only on the final 0; 11 out_valid pulses.
- STUFF_ERR_EN defined, seven consecutive 1s: ignore_bit and stuff_err=1 on the 7th bit; no further out_valid until enable=0; stuff_err=0 one cycle after enable falls.
- Five 1s, then enable=0 for one cycle, then enable=1 and three 1s: no ignore_bit; counter restarts at 0; eight out_valid pulses with out_bit=1.
- RUN_LEN=3, STAT_W=2, pattern (1,1,1,0) repeated five times: ignore_bit every 4th bit; stuff_cnt saturates at 3.
- n_rst pulsed low after four 1s, bit_valid idle gaps between bits: all outputs at reset values immediately; the next run of RUN_LEN ones needs a full count before ignore_bit.
